// File: rtl/mvm_pkg.sv
// Shared defaults and FSM state type for the MVM result serializer.
package mvm_pkg;

  localparam int unsigned R_DEF             = 4;
  localparam int unsigned W_Y_OUT_DEF       = 16;
  localparam int unsigned BITS_PER_WORD_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } ser_state_e;

endpackage

// File: rtl/mvm_y_serializer.sv
// Serializes one captured MVM result vector into UART-sized bytes, row 0 LSB first,
// followed by an XOR checksum byte flagged with m_last.
module mvm_y_serializer
  import mvm_pkg::*;
#(
  parameter int unsigned R             = R_DEF,
  parameter int unsigned W_Y_OUT       = W_Y_OUT_DEF,
  parameter int unsigned BITS_PER_WORD = BITS_PER_WORD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [R*W_Y_OUT-1:0]     s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_last
);

  localparam int unsigned DW    = R * W_Y_OUT;
  localparam int unsigned N     = DW / BITS_PER_WORD;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  ser_state_e               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [BITS_PER_WORD-1:0] csum_q, csum_d;
  logic [DW-1:0]            cap_q, cap_d;
  logic [BITS_PER_WORD-1:0] cur_byte, next_byte;

  logic                     s_ready_q, s_ready_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_last_q, m_last_d;
  logic [BITS_PER_WORD-1:0] m_data_q, m_data_d;

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    cap_d     = cap_q;
    cur_byte  = cap_q[idx_q*BITS_PER_WORD +: BITS_PER_WORD];

    unique case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          cap_d   = s_data;
          idx_d   = '0;
          csum_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_valid_q && m_ready) begin
          csum_d = csum_q ^ cur_byte;
          if (idx_q == IDX_LAST) begin
            state_d = ST_CSUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_CSUM: begin
        if (m_valid_q && m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    next_byte = cap_d[idx_d*BITS_PER_WORD +: BITS_PER_WORD];

    s_ready_d = (state_d == ST_IDLE);
    m_valid_d = (state_d != ST_IDLE);
    m_last_d  = (state_d == ST_CSUM);
    unique case (state_d)
      ST_SEND: m_data_d = next_byte;
      ST_CSUM: m_data_d = csum_d;
      default: m_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      csum_q    <= '0;
      cap_q     <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      cap_q     <= cap_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_mvm_y_serializer.sv
// Directed bench for mvm_y_serializer at default parameters (4 rows x 16 bits, 8-bit bytes).
module tb_mvm_y_serializer;

  typedef logic [7:0] frame_t [9];

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  int n_checks = 0;
  int n_errors = 0;

  mvm_y_serializer dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and hold s_valid for exactly the accepting cycle.
  task automatic send(input logic [63:0] vec, input string tag);
    int cnt;
    s_data  = vec;
    s_valid = 1'b1;
    cnt = 0;
    while (!s_ready && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, " s_ready"}, 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    s_data  = 64'hDEAD_BEEF_0BAD_F00D;
    check({tag, " latency1 m_valid"}, 32'(m_valid), 32'd1);
  endtask

  // Consume the first 'count' bytes of a frame, optionally stalling on one byte.
  task automatic recv(input frame_t exp, input int count, input int stall_at,
                      input int stall_cycles, input string tag);
    int cnt;
    for (int k = 0; k < count; k++) begin
      cnt = 0;
      while (!m_valid && cnt < 20) begin
        step();
        cnt++;
      end
      check($sformatf("%s b%0d valid", tag, k), 32'(m_valid), 32'd1);
      check($sformatf("%s b%0d data", tag, k), 32'(m_data), 32'(exp[k]));
      check($sformatf("%s b%0d last", tag, k), 32'(m_last), (k == 8) ? 32'd1 : 32'd0);
      if (k == stall_at) begin
        m_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          step();
          check($sformatf("%s b%0d hold data", tag, k), 32'(m_data), 32'(exp[k]));
          check($sformatf("%s b%0d hold valid", tag, k), 32'(m_valid), 32'd1);
        end
        m_ready = 1'b1;
      end
      step();
    end
    if (count == 9) begin
      check({tag, " idle s_ready"}, 32'(s_ready), 32'd1);
      check({tag, " idle m_last"}, 32'(m_last), 32'd0);
    end
  endtask

  localparam logic [63:0] VEC_A = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [63:0] VEC_1 = {4{16'hFFFF}};
  localparam logic [63:0] VEC_B = {16'hA55A, 16'h1234, 16'h00FF, 16'hC3F0};
  localparam logic [63:0] VEC_C = {16'h8001, 16'h4002, 16'h2004, 16'h1008};

  frame_t fr_a, fr_1, fr_b, fr_c;

  initial begin
    fr_a = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h04};
    fr_1 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    fr_b = '{8'hF0, 8'hC3, 8'hFF, 8'h00, 8'h34, 8'h12, 8'h5A, 8'hA5, 8'h15};
    fr_c = '{8'h08, 8'h10, 8'h04, 8'h20, 8'h02, 8'h40, 8'h01, 8'h80, 8'hFF};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    step();
    step();
    check("reset s_ready", 32'(s_ready), 32'd1);
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset m_last", 32'(m_last), 32'd0);
    check("reset m_data", 32'(m_data), 32'd0);
    rst = 1'b0;
    step();

    send(VEC_A, "basic");
    recv(fr_a, 9, -1, 0, "basic");
    step();

    send(VEC_A, "bp");
    recv(fr_a, 9, 2, 3, "bp");
    step();

    send(VEC_1, "ones");
    recv(fr_1, 9, -1, 0, "ones");
    step();

    // Back-to-back: s_valid stays high; B sits on s_data while A is still being sent.
    s_data  = VEC_A;
    s_valid = 1'b1;
    step();
    s_data = VEC_B;
    check("b2b first accept", 32'(s_ready), 32'd0);
    recv(fr_a, 9, -1, 0, "b2b_a");
    step();
    check("b2b second accept s_ready", 32'(s_ready), 32'd0);
    check("b2b second accept m_valid", 32'(m_valid), 32'd1);
    s_valid = 1'b0;
    s_data  = '0;
    recv(fr_b, 9, -1, 0, "b2b_b");
    step();

    // Reset mid-frame after bytes 0..3 have been handed off.
    send(VEC_A, "midrst");
    recv(fr_a, 4, -1, 0, "midrst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst m_valid", 32'(m_valid), 32'd0);
    check("midrst s_ready", 32'(s_ready), 32'd1);
    check("midrst m_last", 32'(m_last), 32'd0);
    check("midrst m_data", 32'(m_data), 32'd0);
    step();
    check("midrst stays quiet", 32'(m_valid), 32'd0);
    send(VEC_C, "after_rst");
    recv(fr_c, 9, -1, 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
